// File: rtl/mw_writeback_stage_pkg.sv
// Shared writeback definitions: opcode constants, fixed destination registers
// and the write-type classification used by the MW stage.
package wb_pkg;

   localparam logic [4:0] OP_ALU  = 5'b00000;
   localparam logic [4:0] OP_ADDI = 5'b00101;
   localparam logic [4:0] OP_LW   = 5'b01000;
   localparam logic [4:0] OP_JAL  = 5'b00011;
   localparam logic [4:0] OP_SETX = 5'b10101;

   localparam logic [4:0] REG_LINK   = 5'd31;
   localparam logic [4:0] REG_STATUS = 5'd30;

   typedef enum logic [2:0] {
      WB_NONE,
      WB_ALU,
      WB_MEM,
      WB_LINK,
      WB_SETX,
      WB_EXC
   } wb_kind_e;

endpackage

// File: rtl/mw_writeback_stage_if.sv
// XM-side instruction bus, multdiv completion handshake and regfile write port
// of the MW writeback stage.
interface mw_writeback_stage_if;

   logic        xm_valid;
   logic [31:0] xm_insn;
   logic [31:0] xm_o;
   logic [31:0] xm_pc;
   logic [31:0] dmem_q;
   logic        xm_exc;
   logic [31:0] xm_rstatus;
   logic        md_valid;
   logic [4:0]  md_rd;
   logic [31:0] md_result;
   logic        md_ready;
   logic        wb_stall_req;
   logic        ctrl_writeEnable;
   logic [4:0]  ctrl_writeReg;
   logic [31:0] data_writeReg;

   modport master (
      output xm_valid, xm_insn, xm_o, xm_pc, dmem_q, xm_exc, xm_rstatus,
      output md_valid, md_rd, md_result,
      input  md_ready, wb_stall_req, ctrl_writeEnable, ctrl_writeReg, data_writeReg
   );

   modport slave (
      input  xm_valid, xm_insn, xm_o, xm_pc, dmem_q, xm_exc, xm_rstatus,
      input  md_valid, md_rd, md_result,
      output md_ready, wb_stall_req, ctrl_writeEnable, ctrl_writeReg, data_writeReg
   );

endinterface

// File: rtl/mw_writeback_stage_decoder.sv
// Combinational writeback classifier for the XM instruction.
// MW_EXCEPTION_WB_EN lets the exception flag override the opcode decode.
module wb_decoder
   import wb_pkg::*;
(
   input  logic [4:0] opcode,
   input  logic       exc,
   output wb_kind_e   kind,
   output logic       we
);

   always_comb begin
      kind = WB_NONE;
      case (opcode)
         OP_ALU, OP_ADDI: kind = WB_ALU;
         OP_LW:           kind = WB_MEM;
         OP_JAL:          kind = WB_LINK;
         OP_SETX:         kind = WB_SETX;
         default:         kind = WB_NONE;
      endcase
`ifdef MW_EXCEPTION_WB_EN
      if (exc) kind = WB_EXC;
`endif
      we = (kind != WB_NONE);
   end

`ifndef MW_EXCEPTION_WB_EN
   logic unused_exc;
   assign unused_exc = exc;
`endif

endmodule

// File: rtl/mw_writeback_stage.sv
// MW pipeline register plus a one-entry multdiv result buffer sharing the regfile
// write port. Optional MW_EXCEPTION_WB_EN routes exceptions to r30.
module mw_writeback_stage
   import wb_pkg::*;
(
   input  logic                  clock,
   input  logic                  reset,
   mw_writeback_stage_if.slave   bus
);

   wb_kind_e    xm_kind;
   logic        xm_we;
   logic [4:0]  xm_dest;
   logic [31:0] xm_data;

   logic        mw_write;
   logic [4:0]  mw_rd;
   logic [31:0] mw_data;

   logic        buf_full;
   logic [4:0]  buf_rd;
   logic [31:0] buf_data;

   logic        stall;
   logic        md_accept;

   wb_decoder u_decoder (
      .opcode (bus.xm_insn[31:27]),
      .exc    (bus.xm_exc),
      .kind   (xm_kind),
      .we     (xm_we)
   );

   always_comb begin
      xm_dest = 5'd0;
      xm_data = 32'd0;
      case (xm_kind)
         WB_ALU:  begin xm_dest = bus.xm_insn[26:22]; xm_data = bus.xm_o;                  end
         WB_MEM:  begin xm_dest = bus.xm_insn[26:22]; xm_data = bus.dmem_q;                end
         WB_LINK: begin xm_dest = REG_LINK;           xm_data = bus.xm_pc + 32'd1;         end
         WB_SETX: begin xm_dest = REG_STATUS;         xm_data = {5'd0, bus.xm_insn[26:0]}; end
         WB_EXC:  begin xm_dest = REG_STATUS;         xm_data = bus.xm_rstatus;            end
         default: begin xm_dest = 5'd0;               xm_data = 32'd0;                     end
      endcase
   end

   // A full buffer blocked by an MW write forces a bubble so it drains next cycle.
   assign stall     = buf_full & mw_write;
   assign md_accept = bus.md_valid & ~buf_full;

   always_ff @(posedge clock) begin
      if (reset) begin
         mw_write <= 1'b0;
         mw_rd    <= 5'd0;
         mw_data  <= 32'd0;
         buf_full <= 1'b0;
         buf_rd   <= 5'd0;
         buf_data <= 32'd0;
      end else begin
         if (stall) begin
            mw_write <= 1'b0;
            mw_rd    <= 5'd0;
            mw_data  <= 32'd0;
         end else begin
            mw_write <= bus.xm_valid & xm_we & (xm_dest != 5'd0);
            mw_rd    <= xm_dest;
            mw_data  <= xm_data;
         end

         // Results for r0 are accepted but never occupy the buffer.
         if (md_accept && bus.md_rd != 5'd0) begin
            buf_full <= 1'b1;
            buf_rd   <= bus.md_rd;
            buf_data <= bus.md_result;
         end else if (buf_full && !mw_write) begin
            buf_full <= 1'b0;
         end
      end
   end

   always_comb begin
      bus.ctrl_writeEnable = 1'b0;
      bus.ctrl_writeReg    = 5'd0;
      bus.data_writeReg    = 32'd0;
      if (mw_write) begin
         bus.ctrl_writeEnable = 1'b1;
         bus.ctrl_writeReg    = mw_rd;
         bus.data_writeReg    = mw_data;
      end else if (buf_full) begin
         bus.ctrl_writeEnable = 1'b1;
         bus.ctrl_writeReg    = buf_rd;
         bus.data_writeReg    = buf_data;
      end
   end

   assign bus.md_ready     = ~buf_full;
   assign bus.wb_stall_req = stall;

endmodule

// File: doc/mw_writeback_stage.md
MW_WRITEBACK_STAGE -- requirements
Module: mw_writeback_stage

Interface
REQ-001 SHALL: clock  input  1  single rising-edge clock; one clock; reset is synchronous and active-high.
REQ-002 SHALL: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL: xm_valid  input  1  XM latch holds a real instruction.
REQ-004 SHALL: xm_insn  input  32  instruction; opcode [31:27], rd [26:22], target [26:0].
REQ-005 SHALL: xm_o  input  32  ALU result.
REQ-006 SHALL: xm_pc  input  32  instruction PC.
REQ-007 SHALL: dmem_q  input  32  load data, valid in the same cycle as XM.
REQ-008 SHALL: xm_exc, xm_rstatus  input  1/32  exception flag and status value.
REQ-009 SHALL: md_valid, md_rd, md_result  input  1/5/32  multdiv completion.
REQ-010 SHALL: md_ready  output  1  multdiv result accepted at this edge when md_valid is high.
REQ-011 SHALL: wb_stall_req  output  1  upstream holds XM this cycle.
REQ-012 SHALL: ctrl_writeEnable, ctrl_writeReg, data_writeReg  output  1/5/32  regfile write port; also used as the bypass source.

Function
REQ-013 SHALL: latency is 1 cycle; XM is captured into the MW register at the edge, and the write port is driven from the MW register.
REQ-014 SHALL: writing opcodes are ALU 00000, addi 00101, lw 01000, jal 00011 and setx 10101; all other opcodes write nothing.
REQ-015 SHALL: destination and data per type: ALU/addi -> rd and xm_o; lw -> rd and dmem_q; jal -> r31 and xm_pc+1 (mod 2^32); setx -> r30 and the zero-extended target.
REQ-016 SHALL: when xm_exc=1, the write goes to r30 with data xm_rstatus, overriding the opcode decode.
REQ-017 SHALL: a destination of r0 suppresses the pipeline write (ctrl_writeEnable=0).
REQ-018 SHALL: the multdiv buffer is one entry; md_ready = ~buf_full; the buffer loads on md_valid&md_ready; a multdiv result with md_rd=0 is accepted and then discarded.
REQ-019 SHALL: port priority: an MW write wins; otherwise a full buffer drives the port and empties at that edge.
REQ-020 SHALL: wb_stall_req = buf_full & (MW write pending); at that edge MW loads a bubble, so the buffer drains on the next cycle (bounded 1-cycle wait).
REQ-021 SHALL: if the buffer drains and md_valid arrives on the same edge, the new result is refused (md_ready=0) and is accepted on the following cycle.
REQ-022 SHALL: when xm_valid=0 or a bubble is loaded, the MW register holds valid=0 and no pipeline write occurs.

Reset
REQ-023 SHALL: reset clears the MW valid bit and buf_full, and drives ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0, md_ready=1 and wb_stall_req=0 in the following cycle.
REQ-024 SHALL: a reset asserted mid-operation discards any buffered multdiv result; the multdiv unit is reset by the same signal.

Configuration
REQ-025 SHALL: with MW_EXCEPTION_WB_EN defined, REQ-016 applies.
REQ-026 SHALL: without MW_EXCEPTION_WB_EN, xm_exc and xm_rstatus are ignored and the opcode decode alone selects the write.

Structure
REQ-027 SHALL: the shared package wb_pkg holds the opcode constants, REG_LINK=31, REG_STATUS=30 and the enum {WB_NONE, WB_ALU, WB_MEM, WB_LINK, WB_SETX, WB_EXC}.
REQ-028 SHALL: the sub-module wb_decoder is combinational; it maps the opcode and exception flag to the enum and the write-enable, and is instantiated once on the XM side.

Verification
REQ-029 SHALL: addi r5 with xm_o=0x1234 -> next cycle ctrl_writeEnable=1, ctrl_writeReg=5, data_writeReg=0x1234.
REQ-030 SHALL: jal at xm_pc=0xFFFFFFFF -> ctrl_writeReg=31, data_writeReg=0x00000000.
REQ-031 SHALL: ALU op with rd=0 -> ctrl_writeEnable=0; sw (00111) -> ctrl_writeEnable=0.
REQ-032 SHALL: md_valid with md_rd=7 and md_result=0xBEEF during back-to-back lw writes -> buffer fills, md_ready=0, wb_stall_req=1 for one cycle, bubble, then r7<=0xBEEF.
REQ-033 SHALL: xm_exc=1 with xm_rstatus=3 on an add to r4 -> write r30<=3 when MW_EXCEPTION_WB_EN is defined, and write r4 otherwise.
REQ-034 SHALL: reset asserted while the buffer is full -> the next cycle shows md_ready=1, no write and wb_stall_req=0.
